variable_table_scheduler: RTL

//  Sequences and shares the 1b true-dual-port read-first variable table. Port A: owned by the scheduler
//  for init sweeps and read-modify-write flips. Port B (read-only): round-robin between two readers
//  (clause evaluator = rd0, break-count unit = rd1). Blocks reads of an address while its flip is in flight.

---
 rtl/variable_table_scheduler_if.sv | 37 +++
 rtl/variable_table_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/variable_table_scheduler_if.sv
// Client-side handshake bundle for the variable table scheduler.
// Carries the init sweep, flip requests and the two shared read ports.
interface variable_table_scheduler_if #(
  parameter int unsigned AW = 11
);
  logic          start_init;
  logic          init_bit;
  logic          init_done;
  logic          flip_valid;
  logic          flip_ready;
  logic [AW-1:0] flip_addr;
  logic          flip_done;
  logic          flip_old;
  logic          rd0_valid;
  logic          rd0_ready;
  logic [AW-1:0] rd0_addr;
  logic          rd1_valid;
  logic          rd1_ready;
  logic [AW-1:0] rd1_addr;
  logic          rd_rvalid;
  logic          rd_rid;
  logic          rd_rdata;

  modport master (
    output start_init, init_bit, flip_valid, flip_addr,
           rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    input  init_done, flip_ready, flip_done, flip_old,
           rd0_ready, rd1_ready, rd_rvalid, rd_rid, rd_rdata
  );

  modport slave (
    input  start_init, init_bit, flip_valid, flip_addr,
           rd0_valid, rd0_addr, rd1_valid, rd1_addr,
    output init_done, flip_ready, flip_done, flip_old,
           rd0_ready, rd1_ready, rd_rvalid, rd_rid, rd_rdata
  );
endinterface

// File: rtl/variable_table_scheduler.sv
// Owns port A of the 1b read-first variable table (init sweep, read-modify-write flips)
// and round-robins read-only port B between the clause evaluator (rd0) and break-count unit (rd1).
module variable_table_scheduler #(
  parameter int unsigned VARIABLE_ADDRESS_WIDTH = 11
) (
  input  logic                              clk,
  input  logic                              rst,
  variable_table_scheduler_if.slave         bus,
  output logic                              tbl_en_a,
  output logic                              tbl_we_a,
  output logic                              tbl_din_a,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0] tbl_addr_a,
  input  logic                              tbl_dout_a,
  output logic                              tbl_en_b,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0] tbl_addr_b,
  input  logic                              tbl_dout_b
);

  localparam int unsigned     AW        = VARIABLE_ADDRESS_WIDTH;
  localparam logic [AW-1:0]   LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INIT    = 2'd1,
    S_FLIP_RD = 2'd2,
    S_FLIP_WR = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_flip_addr;
  logic          r_flip_old;
  logic          r_flip_done;
  logic          r_init_done;
  logic          r_rr_ptr;
  logic          r_rvalid;
  logic          r_rid;

  logic          w_flip_ready;
  logic          w_flip_accept;
  logic          w_init_active;
  logic          w_flip_busy;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_gnt0;
  logic          w_gnt1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start_init has priority over a same-cycle flip
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_init)      w_state_nxt = S_INIT;
        else if (bus.flip_valid) w_state_nxt = S_FLIP_RD;
      end
      S_INIT: begin
        if (r_cnt == LAST_ADDR)  w_state_nxt = S_IDLE;
      end
      S_FLIP_RD:                 w_state_nxt = S_FLIP_WR;
      S_FLIP_WR:                 w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Port A drive and flip handshake, decoded from the current state
  always_comb begin
    tbl_en_a      = 1'b0;
    tbl_we_a      = 1'b0;
    tbl_din_a     = 1'b0;
    tbl_addr_a    = '0;
    w_flip_ready  = 1'b0;
    w_init_active = 1'b0;
    w_flip_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_flip_ready = ~bus.start_init;
      end
      S_INIT: begin
        w_init_active = 1'b1;
        tbl_en_a      = 1'b1;
        tbl_we_a      = 1'b1;
        tbl_din_a     = bus.init_bit;
        tbl_addr_a    = r_cnt;
      end
      S_FLIP_RD: begin
        w_flip_busy = 1'b1;
        tbl_en_a    = 1'b1;
        tbl_addr_a  = r_flip_addr;
      end
      S_FLIP_WR: begin
        w_flip_busy = 1'b1;
        tbl_en_a    = 1'b1;
        tbl_we_a    = 1'b1;
        tbl_din_a   = ~tbl_dout_a;
        tbl_addr_a  = r_flip_addr;
      end
      default: begin
        w_flip_ready = 1'b0;
      end
    endcase
  end

  assign w_flip_accept = bus.flip_valid & w_flip_ready;

  // Sweep counter, flip address/old-value capture and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_flip_addr <= '0;
      r_flip_old  <= 1'b0;
      r_flip_done <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= (r_state == S_INIT) && (r_cnt == LAST_ADDR);
      r_flip_done <= (r_state == S_FLIP_WR);
      if ((r_state == S_IDLE) && bus.start_init) r_cnt <= '0;
      else if (r_state == S_INIT)                r_cnt <= r_cnt + AW'(1);
      if (w_flip_accept)          r_flip_addr <= bus.flip_addr;
      if (r_state == S_FLIP_WR)   r_flip_old  <= tbl_dout_a;
    end
  end

  // Port B arbitration; a reader aimed at the in-flight flip address waits until it lands
  always_comb begin
    w_elig0 = bus.rd0_valid && !w_init_active && !(w_flip_busy && (bus.rd0_addr == r_flip_addr));
    w_elig1 = bus.rd1_valid && !w_init_active && !(w_flip_busy && (bus.rd1_addr == r_flip_addr));
    w_gnt0  = w_elig0 && (!w_elig1 || !r_rr_ptr);
    w_gnt1  = w_elig1 && (!w_elig0 ||  r_rr_ptr);
    tbl_en_b   = w_gnt0 | w_gnt1;
    tbl_addr_b = '0;
    if (w_gnt0)      tbl_addr_b = bus.rd0_addr;
    else if (w_gnt1) tbl_addr_b = bus.rd1_addr;
  end

  // Round-robin pointer and read-return tagging
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
      r_rvalid <= 1'b0;
      r_rid    <= 1'b0;
    end else begin
      if (w_gnt0)      r_rr_ptr <= 1'b1;
      else if (w_gnt1) r_rr_ptr <= 1'b0;
      r_rvalid <= w_gnt0 | w_gnt1;
      r_rid    <= w_gnt1;
    end
  end

  assign bus.flip_ready = w_flip_ready;
  assign bus.flip_done  = r_flip_done;
  assign bus.flip_old   = r_flip_old;
  assign bus.init_done  = r_init_done;
  assign bus.rd0_ready  = w_gnt0;
  assign bus.rd1_ready  = w_gnt1;
  assign bus.rd_rvalid  = r_rvalid;
  assign bus.rd_rid     = r_rid;
  assign bus.rd_rdata   = tbl_dout_b;

endmodule
